// File: rtl/mem_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
//   Shared definitions for the data-memory bus arbiter and its address decoder:
//   default bus widths, the RAM/IO address map, FSM state encodings and the
//   master identifiers.
//   No ports (package).
// -----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

    // Default widths
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Address map (byte addresses)
    localparam int unsigned RAM_BASE_DEF = 0;
    localparam int unsigned RAM_SIZE_DEF = 1024;
    localparam int unsigned IO_BASE_DEF  = 1024;
    localparam int unsigned IO_SIZE_DEF  = 1024;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_e;

endpackage : mem_bus_arbiter_pkg

// File: rtl/mem_bus_arbiter_addr_decode.sv
// -----------------------------------------------------------------------------
// mem_addr_decode
//   Combinational address decoder for the data-memory map. Also intended for
//   reuse by the instruction-fetch path.
//   Ports:
//     addr     in   ADDR_W  byte address
//     sel_ram  out  1       address hits RAM and is word aligned
//     sel_io   out  1       address hits IO and is word aligned
//     err      out  1       out of range or not word aligned
// -----------------------------------------------------------------------------
module mem_addr_decode
    import mem_bus_arbiter_pkg::*;
#(
    parameter int          ADDR_W   = ADDR_W_DEF,
    parameter int unsigned RAM_BASE = RAM_BASE_DEF,
    parameter int unsigned RAM_SIZE = RAM_SIZE_DEF,
    parameter int unsigned IO_BASE  = IO_BASE_DEF,
    parameter int unsigned IO_SIZE  = IO_SIZE_DEF
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              sel_ram,
    output logic              sel_io,
    output logic              err
);

    // One extra bit so base+size never wraps and an address below the base
    // turns into a huge offset after the subtraction.
    localparam logic [ADDR_W:0] RAM_LO = (ADDR_W+1)'(RAM_BASE);
    localparam logic [ADDR_W:0] RAM_SZ = (ADDR_W+1)'(RAM_SIZE);
    localparam logic [ADDR_W:0] IO_LO  = (ADDR_W+1)'(IO_BASE);
    localparam logic [ADDR_W:0] IO_SZ  = (ADDR_W+1)'(IO_SIZE);

    logic [ADDR_W:0] ram_off;
    logic [ADDR_W:0] io_off;
    logic            aligned;
    logic            in_ram;
    logic            in_io;

    always_comb begin
        ram_off = {1'b0, addr} - RAM_LO;
        io_off  = {1'b0, addr} - IO_LO;
        in_ram  = (ram_off < RAM_SZ);
        in_io   = (io_off < IO_SZ);
        aligned = (addr[1:0] == 2'b00);
        sel_ram = aligned && in_ram;
        sel_io  = aligned && !in_ram && in_io;
        err     = !(sel_ram || sel_io);
    end

endmodule : mem_addr_decode

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares the data-memory bus between the CPU MEM stage (m0) and the debug /
//   program-loader port (m1). Round-robin arbitration, one access per grant,
//   fixed IDLE -> ACCESS -> DONE sequence (ack two cycles after request).
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     mN_req/we/addr/wdata          master request (held until mN_ack)
//     mN_ack/rdata/err              one-cycle completion, read data, error flag
//     ram_ce, io_ce                 slave chip enables (ACCESS cycle only)
//     bus_we/addr/wdata             slave write enable, address, write data
//     bus_rdata                     shared slave read data (Z when unselected)
// -----------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int          ADDR_W   = ADDR_W_DEF,
    parameter int          DATA_W   = DATA_W_DEF,
    parameter int unsigned RAM_BASE = RAM_BASE_DEF,
    parameter int unsigned RAM_SIZE = RAM_SIZE_DEF,
    parameter int unsigned IO_BASE  = IO_BASE_DEF,
    parameter int unsigned IO_SIZE  = IO_SIZE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              ram_ce,
    output logic              io_ce,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata
);

    state_e            state_q, state_d;
    master_e           last_grant_q, last_grant_d;
    master_e           winner;
    logic              any_req;
    logic [ADDR_W-1:0] win_addr;

    // Latched transaction
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              sel_ram_q, sel_ram_d;
    logic              sel_io_q, sel_io_d;
    logic              err_q, err_d;

    // Registered master responses
    logic              m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
    logic              m0_err_q, m0_err_d, m1_err_q, m1_err_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

    logic              dec_ram, dec_io, dec_err;
    logic              in_access;
    logic [DATA_W-1:0] rd_word;

    // Round-robin pick: a sole requester wins, a tie goes to the master that
    // was not granted last.
    always_comb begin
        any_req = m0_req || m1_req;
        if (m0_req && m1_req) begin
            winner = (last_grant_q == M0) ? M1 : M0;
        end else if (m1_req) begin
            winner = M1;
        end else begin
            winner = M0;
        end
        win_addr = (winner == M1) ? m1_addr : m0_addr;
    end

    mem_addr_decode #(
        .ADDR_W   (ADDR_W),
        .RAM_BASE (RAM_BASE),
        .RAM_SIZE (RAM_SIZE),
        .IO_BASE  (IO_BASE),
        .IO_SIZE  (IO_SIZE)
    ) u_decode (
        .addr    (win_addr),
        .sel_ram (dec_ram),
        .sel_io  (dec_io),
        .err     (dec_err)
    );

    // State register and all flops
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= M1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            sel_ram_q    <= 1'b0;
            sel_io_q     <= 1'b0;
            err_q        <= 1'b0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_err_q     <= 1'b0;
            m1_err_q     <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            sel_ram_q    <= sel_ram_d;
            sel_io_q     <= sel_io_d;
            err_q        <= err_d;
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
            m0_err_q     <= m0_err_d;
            m1_err_q     <= m1_err_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    // Next-state and transaction latch
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned, which would infer a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        sel_ram_d    = sel_ram_q;
        sel_io_d     = sel_io_q;
        err_d        = err_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d      = ST_ACCESS;
                    last_grant_d = winner;
                    we_d         = (winner == M1) ? m1_we : m0_we;
                    addr_d       = win_addr;
                    wdata_d      = (winner == M1) ? m1_wdata : m0_wdata;
                    sel_ram_d    = dec_ram;
                    sel_io_d     = dec_io;
                    err_d        = dec_err;
                end
            end
            ST_ACCESS: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs. Chip enables are gated with rst so a reset landing on the
    // ACCESS cycle can never commit a slave write.
    always_comb begin
        in_access  = (state_q == ST_ACCESS);
        ram_ce     = in_access && sel_ram_q && !rst;
        io_ce      = in_access && sel_io_q && !rst;
        bus_we     = in_access && we_q;
        bus_addr   = addr_q;
        bus_wdata  = wdata_q;
        // Error reads see an undriven bus, so never capture it.
        rd_word    = (!we_q && !err_q) ? bus_rdata : '0;
        m0_ack_d   = in_access && (last_grant_q == M0);
        m1_ack_d   = in_access && (last_grant_q == M1);
        m0_err_d   = m0_ack_d && err_q;
        m1_err_d   = m1_ack_d && err_q;
        m0_rdata_d = m0_ack_d ? rd_word : '0;
        m1_rdata_d = m1_ack_d ? rd_word : '0;
    end

    assign m0_ack   = m0_ack_q;
    assign m1_ack   = m1_ack_q;
    assign m0_err   = m0_err_q;
    assign m1_err   = m1_err_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;

endmodule : mem_bus_arbiter
